snitch_icache_miss_handler: RTL and testbench

Blocking miss handler sitting downstream of the L1 instruction-cache lookup stage. Consumes lookup results, returns hits to the fetch side, and services a single outstanding miss at a time. On a miss it issues a line refill, writes the returned line and tag back through the lookup stage's write port into a round-robin victim way, then returns the refilled line.

---
 rtl/snitch_icache_miss_handler.sv | 200 ++++++++++++++++++++
 tb/tb_snitch_icache_miss_handler.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_miss_handler.sv
// snitch_icache_miss_handler
// Blocking miss handler behind the L1 instruction-cache lookup stage.
// Hits are passed straight through to the fetch side with no registers.
// A miss is serviced on its own, start to finish: refill request, refill
// beat, write into a round-robin victim way, then the line is returned.
// The lookup stage is held off (in_ready_o low) until the miss completes.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. A valid output, once raised, holds with a stable
// payload until that edge. Ready outputs may depend on the valid input.
//
// Optional feature: define SNITCH_ICACHE_ERR_NO_ALLOC_EN so that erroneous
// refill lines are never allocated. Those misses skip the cache write, leave
// the victim pointer untouched and return the line with rsp_error_o set.
// When it is not defined, erroneous lines are written like any other line,
// with write_error_o set.
module snitch_icache_miss_handler #(
   parameter int FETCH_AW    = 32,
   parameter int ID_WIDTH    = 4,
   parameter int LINE_WIDTH  = 128,
   parameter int LINE_ALIGN  = 4,
   parameter int COUNT_ALIGN = 6,
   parameter int SET_ALIGN   = 2,
   parameter int WAY_COUNT   = 4,
   parameter int TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN
) (
   input  logic                   clk_i,
   input  logic                   rst_i,

   // Lookup result from the tag/data lookup stage
   input  logic [FETCH_AW-1:0]    in_addr_i,
   input  logic [ID_WIDTH-1:0]    in_id_i,
   input  logic [SET_ALIGN-1:0]   in_set_i,
   input  logic                   in_hit_i,
   input  logic [LINE_WIDTH-1:0]  in_data_i,
   input  logic                   in_error_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,

   // Response to the fetch side
   output logic [LINE_WIDTH-1:0]  rsp_data_o,
   output logic                   rsp_error_o,
   output logic [ID_WIDTH-1:0]    rsp_id_o,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,

   // Refill request
   output logic [FETCH_AW-1:0]    refill_addr_o,
   output logic                   refill_valid_o,
   input  logic                   refill_ready_i,

   // Refill response
   input  logic [LINE_WIDTH-1:0]  refill_data_i,
   input  logic                   refill_error_i,
   input  logic                   refill_rvalid_i,
   output logic                   refill_rready_o,

   // Cache write port of the lookup stage
   output logic [COUNT_ALIGN-1:0] write_addr_o,
   output logic [SET_ALIGN-1:0]   write_set_o,
   output logic [LINE_WIDTH-1:0]  write_data_o,
   output logic [TAG_WIDTH-1:0]   write_tag_o,
   output logic                   write_error_o,
   output logic                   write_valid_o,
   input  logic                   write_ready_i
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [FETCH_AW-1:0]     addr_q, addr_d;
   logic [ID_WIDTH-1:0]     id_q, id_d;
   logic [LINE_WIDTH-1:0]   data_q, data_d;
   logic                    err_q, err_d;
   logic [SET_ALIGN-1:0]    victim_q, victim_d;
   logic [SET_ALIGN-1:0]    victim_next;

   // The hit way and the byte offset inside a line carry no information here.
   logic unused_bits;
   assign unused_bits = ^{in_set_i, addr_q[LINE_ALIGN-1:0]};

   // Round-robin successor of the current victim way, wrapping at WAY_COUNT.
   always_comb begin
      victim_next = victim_q + 1'b1;
      if (WAY_COUNT <= 1 || victim_q == SET_ALIGN'(WAY_COUNT - 1)) begin
         victim_next = '0;
      end
   end

   // Miss-path payloads come straight from the captured registers.
   assign refill_addr_o = {addr_q[FETCH_AW-1:LINE_ALIGN], {LINE_ALIGN{1'b0}}};
   assign write_addr_o  = addr_q[LINE_ALIGN +: COUNT_ALIGN];
   assign write_tag_o   = addr_q[FETCH_AW-1 -: TAG_WIDTH];
   assign write_set_o   = victim_q;
   assign write_data_o  = data_q;
   assign write_error_o = err_q;

   // State and datapath registers; reset abandons any miss in progress.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         id_q     <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         victim_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         id_q     <= id_d;
         data_q   <= data_d;
         err_q    <= err_d;
         victim_q <= victim_d;
      end
   end

   // Next-state and output decode for the miss FSM plus the hit bypass.
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      id_d            = id_q;
      data_d          = data_q;
      err_d           = err_q;
      victim_d        = victim_q;
      in_ready_o      = 1'b0;
      rsp_valid_o     = 1'b0;
      rsp_data_o      = data_q;
      rsp_error_o     = err_q;
      rsp_id_o        = id_q;
      refill_valid_o  = 1'b0;
      refill_rready_o = 1'b0;
      write_valid_o   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Hits bypass every register; misses are always accepted here.
            rsp_data_o  = in_data_i;
            rsp_error_o = in_error_i;
            rsp_id_o    = in_id_i;
            rsp_valid_o = in_valid_i & in_hit_i;
            in_ready_o  = in_hit_i ? rsp_ready_i : 1'b1;
            if (in_valid_i && !in_hit_i) begin
               addr_d  = in_addr_i;
               id_d    = in_id_i;
               state_d = REQ;
            end
         end
         REQ: begin
            refill_valid_o = 1'b1;
            if (refill_ready_i) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            refill_rready_o = 1'b1;
            if (refill_rvalid_i) begin
               data_d = refill_data_i;
               err_d  = refill_error_i;
`ifdef SNITCH_ICACHE_ERR_NO_ALLOC_EN
               state_d = refill_error_i ? RESP : WRITE;
`else
               state_d = WRITE;
`endif
            end
         end
         WRITE: begin
            write_valid_o = 1'b1;
            if (write_ready_i) begin
               victim_d = victim_next;
               state_d  = RESP;
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Nothing handshakes while reset is held, including the hit bypass.
      if (rst_i) begin
         in_ready_o      = 1'b0;
         rsp_valid_o     = 1'b0;
         refill_valid_o  = 1'b0;
         refill_rready_o = 1'b0;
         write_valid_o   = 1'b0;
      end
   end

endmodule

// File: tb/tb_snitch_icache_miss_handler.sv
// tb_snitch_icache_miss_handler
// Directed bench for the instruction-cache miss handler, built with three
// ways so the victim pointer wrap is visible. Honours
// SNITCH_ICACHE_ERR_NO_ALLOC_EN for the refill-error expectations.
module tb_snitch_icache_miss_handler;

   localparam int FETCH_AW    = 32;
   localparam int ID_WIDTH    = 4;
   localparam int LINE_WIDTH  = 128;
   localparam int LINE_ALIGN  = 4;
   localparam int COUNT_ALIGN = 6;
   localparam int SET_ALIGN   = 2;
   localparam int WAY_COUNT   = 3;
   localparam int TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN;

   localparam logic [LINE_WIDTH-1:0] D_HIT = {16{8'hA5}};
   localparam logic [LINE_WIDTH-1:0] D1    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [LINE_WIDTH-1:0] D2    = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
   localparam logic [LINE_WIDTH-1:0] D3    = 128'h1357_9BDF_2468_ACE0_0F0F_F0F0_A5A5_5A5A;
   localparam logic [LINE_WIDTH-1:0] D4    = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0BAD_BEEF;
   localparam logic [LINE_WIDTH-1:0] D5    = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic [FETCH_AW-1:0]    in_addr_i;
   logic [ID_WIDTH-1:0]    in_id_i;
   logic [SET_ALIGN-1:0]   in_set_i;
   logic                   in_hit_i;
   logic [LINE_WIDTH-1:0]  in_data_i;
   logic                   in_error_i;
   logic                   in_valid_i;
   logic                   in_ready_o;
   logic [LINE_WIDTH-1:0]  rsp_data_o;
   logic                   rsp_error_o;
   logic [ID_WIDTH-1:0]    rsp_id_o;
   logic                   rsp_valid_o;
   logic                   rsp_ready_i;
   logic [FETCH_AW-1:0]    refill_addr_o;
   logic                   refill_valid_o;
   logic                   refill_ready_i;
   logic [LINE_WIDTH-1:0]  refill_data_i;
   logic                   refill_error_i;
   logic                   refill_rvalid_i;
   logic                   refill_rready_o;
   logic [COUNT_ALIGN-1:0] write_addr_o;
   logic [SET_ALIGN-1:0]   write_set_o;
   logic [LINE_WIDTH-1:0]  write_data_o;
   logic [TAG_WIDTH-1:0]   write_tag_o;
   logic                   write_error_o;
   logic                   write_valid_o;
   logic                   write_ready_i;

   int n_assert = 0;
   int n_fail   = 0;

   // Clock and DUT
   always #5 clk_i = ~clk_i;

   snitch_icache_miss_handler #(
      .FETCH_AW   (FETCH_AW),
      .ID_WIDTH   (ID_WIDTH),
      .LINE_WIDTH (LINE_WIDTH),
      .LINE_ALIGN (LINE_ALIGN),
      .COUNT_ALIGN(COUNT_ALIGN),
      .SET_ALIGN  (SET_ALIGN),
      .WAY_COUNT  (WAY_COUNT),
      .TAG_WIDTH  (TAG_WIDTH)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .in_addr_i      (in_addr_i),
      .in_id_i        (in_id_i),
      .in_set_i       (in_set_i),
      .in_hit_i       (in_hit_i),
      .in_data_i      (in_data_i),
      .in_error_i     (in_error_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .rsp_data_o     (rsp_data_o),
      .rsp_error_o    (rsp_error_o),
      .rsp_id_o       (rsp_id_o),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .refill_addr_o  (refill_addr_o),
      .refill_valid_o (refill_valid_o),
      .refill_ready_i (refill_ready_i),
      .refill_data_i  (refill_data_i),
      .refill_error_i (refill_error_i),
      .refill_rvalid_i(refill_rvalid_i),
      .refill_rready_o(refill_rready_o),
      .write_addr_o   (write_addr_o),
      .write_set_o    (write_set_o),
      .write_data_o   (write_data_o),
      .write_tag_o    (write_tag_o),
      .write_error_o  (write_error_o),
      .write_valid_o  (write_valid_o),
      .write_ready_i  (write_ready_i)
   );

   // One comparison point.
   task automatic check(input string tag, input logic [LINE_WIDTH-1:0] obs,
                        input logic [LINE_WIDTH-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // All handshake-valid/ready outputs low.
   task automatic check_quiet(input string tag);
      check({tag, ".in_ready"},      in_ready_o,      1'b0);
      check({tag, ".rsp_valid"},     rsp_valid_o,     1'b0);
      check({tag, ".refill_valid"},  refill_valid_o,  1'b0);
      check({tag, ".refill_rready"}, refill_rready_o, 1'b0);
      check({tag, ".write_valid"},   write_valid_o,   1'b0);
   endtask

   // One miss with every downstream ready/valid held high, checking the
   // cycle-by-cycle timeline T..T+5. Called just after a rising edge.
   task automatic miss_all_ready(input string tag,
                                 input logic [FETCH_AW-1:0]    addr,
                                 input logic [ID_WIDTH-1:0]    id,
                                 input logic [LINE_WIDTH-1:0]  data,
                                 input logic                   err,
                                 input logic [FETCH_AW-1:0]    exp_raddr,
                                 input logic [COUNT_ALIGN-1:0] exp_waddr,
                                 input logic [TAG_WIDTH-1:0]   exp_tag,
                                 input logic [SET_ALIGN-1:0]   exp_set);
      in_valid_i      = 1'b1;
      in_hit_i        = 1'b0;
      in_addr_i       = addr;
      in_id_i         = id;
      refill_ready_i  = 1'b1;
      refill_rvalid_i = 1'b1;
      refill_data_i   = data;
      refill_error_i  = err;
      write_ready_i   = 1'b1;
      rsp_ready_i     = 1'b1;
      #1;
      check({tag, ".T.in_ready"}, in_ready_o, 1'b1);
      tick();
      in_valid_i = 1'b0;
      #1;
      check({tag, ".T1.refill_valid"}, refill_valid_o, 1'b1);
      check({tag, ".T1.refill_addr"},  refill_addr_o,  exp_raddr);
      check({tag, ".T1.in_ready"},     in_ready_o,     1'b0);
      tick();
      check({tag, ".T2.refill_rready"}, refill_rready_o, 1'b1);
      tick();
`ifdef SNITCH_ICACHE_ERR_NO_ALLOC_EN
      if (err) begin
         check({tag, ".T3.write_valid"}, write_valid_o, 1'b0);
         check({tag, ".T3.rsp_valid"},   rsp_valid_o,   1'b1);
         check({tag, ".T3.rsp_error"},   rsp_error_o,   1'b1);
         check({tag, ".T3.rsp_data"},    rsp_data_o,    data);
         tick();
         check({tag, ".T4.in_ready"},    in_ready_o,    1'b1);
         check({tag, ".T4.rsp_valid"},   rsp_valid_o,   1'b0);
         return;
      end
`endif
      check({tag, ".T3.write_valid"}, write_valid_o, 1'b1);
      check({tag, ".T3.write_addr"},  write_addr_o,  exp_waddr);
      check({tag, ".T3.write_tag"},   write_tag_o,   exp_tag);
      check({tag, ".T3.write_set"},   write_set_o,   exp_set);
      check({tag, ".T3.write_data"},  write_data_o,  data);
      check({tag, ".T3.write_error"}, write_error_o, err);
      check({tag, ".T3.rsp_valid"},   rsp_valid_o,   1'b0);
      tick();
      check({tag, ".T4.rsp_valid"},   rsp_valid_o,   1'b1);
      check({tag, ".T4.rsp_data"},    rsp_data_o,    data);
      check({tag, ".T4.rsp_id"},      rsp_id_o,      id);
      check({tag, ".T4.rsp_error"},   rsp_error_o,   err);
      check({tag, ".T4.write_valid"}, write_valid_o, 1'b0);
      tick();
      check({tag, ".T5.in_ready"},    in_ready_o,    1'b1);
      check({tag, ".T5.rsp_valid"},   rsp_valid_o,   1'b0);
   endtask

   // Directed stimulus
   initial begin
      rst_i           = 1'b1;
      in_addr_i       = '0;
      in_id_i         = '0;
      in_set_i        = '0;
      in_hit_i        = 1'b0;
      in_data_i       = '0;
      in_error_i      = 1'b0;
      in_valid_i      = 1'b0;
      rsp_ready_i     = 1'b0;
      refill_ready_i  = 1'b0;
      refill_data_i   = '0;
      refill_error_i  = 1'b0;
      refill_rvalid_i = 1'b0;
      write_ready_i   = 1'b0;

      // Reset: even a presented hit must not produce a response.
      tick();
      in_valid_i  = 1'b1;
      in_hit_i    = 1'b1;
      in_data_i   = D_HIT;
      rsp_ready_i = 1'b1;
      #1;
      check_quiet("reset");
      tick();
      rst_i      = 1'b0;
      in_valid_i = 1'b0;
      in_hit_i   = 1'b0;
      #1;
      check("post_reset.in_ready", in_ready_o,  1'b1);
      check("post_reset.rsp_valid", rsp_valid_o, 1'b0);

      // Hit pass-through, same cycle.
      tick();
      in_valid_i  = 1'b1;
      in_hit_i    = 1'b1;
      in_data_i   = D_HIT;
      in_error_i  = 1'b0;
      in_id_i     = 4'd3;
      in_set_i    = 2'd2;
      rsp_ready_i = 1'b1;
      #1;
      check("hit.rsp_valid", rsp_valid_o, 1'b1);
      check("hit.rsp_data",  rsp_data_o,  D_HIT);
      check("hit.rsp_id",    rsp_id_o,    4'd3);
      check("hit.rsp_error", rsp_error_o, 1'b0);
      check("hit.in_ready",  in_ready_o,  1'b1);
      check("hit.refill_valid", refill_valid_o, 1'b0);
      rsp_ready_i = 1'b0;
      in_error_i  = 1'b1;
      #1;
      check("hit_stall.in_ready",  in_ready_o,  1'b0);
      check("hit_stall.rsp_valid", rsp_valid_o, 1'b1);
      check("hit_stall.rsp_error", rsp_error_o, 1'b1);
      tick();
      in_valid_i = 1'b0;
      in_hit_i   = 1'b0;
      in_error_i = 1'b0;

      // First miss, then round-robin over three ways: 0,1,2,0.
      miss_all_ready("miss1", 32'h0001_2340, 4'd5, D1, 1'b0,
                     32'h0001_2340, 6'h34, 22'h48, 2'd0);
      miss_all_ready("rr2", 32'h0000_0104, 4'd6, D2, 1'b0,
                     32'h0000_0100, 6'h10, 22'h0, 2'd1);
      miss_all_ready("rr3", 32'hFFFF_FFFC, 4'd7, D3, 1'b0,
                     32'hFFFF_FFF0, 6'h3F, 22'h3F_FFFF, 2'd2);
      miss_all_ready("rr4", 32'h8000_0420, 4'd8, D4, 1'b0,
                     32'h8000_0420, 6'h02, 22'h20_0001, 2'd0);

      // Refill error on a line that would go to way 1.
      miss_all_ready("err", 32'h0000_0800, 4'd1, D2, 1'b1,
                     32'h0000_0800, 6'h00, 22'h2, 2'd1);

      // Back-pressure on all three miss-path handshakes; a hit waits behind.
      in_valid_i      = 1'b1;
      in_hit_i        = 1'b0;
      in_addr_i       = 32'h0000_ABC8;
      in_id_i         = 4'd9;
      refill_ready_i  = 1'b0;
      refill_rvalid_i = 1'b0;
      refill_error_i  = 1'b0;
      refill_data_i   = D3;
      write_ready_i   = 1'b0;
      rsp_ready_i     = 1'b0;
      #1;
      check("bp.accept", in_ready_o, 1'b1);
      tick();
      in_hit_i  = 1'b1;
      in_data_i = D_HIT;
      in_id_i   = 4'd4;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp.req.refill_valid", refill_valid_o, 1'b1);
         check("bp.req.refill_addr",  refill_addr_o,  32'h0000_ABC0);
         check("bp.req.in_ready",     in_ready_o,     1'b0);
         check("bp.req.rsp_valid",    rsp_valid_o,    1'b0);
         tick();
      end
      refill_ready_i = 1'b1;
      tick();
      refill_ready_i  = 1'b0;
      refill_rvalid_i = 1'b1;
      #1;
      check("bp.wait.refill_rready", refill_rready_o, 1'b1);
      check("bp.wait.refill_valid",  refill_valid_o,  1'b0);
      tick();
      refill_rvalid_i = 1'b0;
      refill_data_i   = D5;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp.write.valid", write_valid_o, 1'b1);
         check("bp.write.data",  write_data_o,  D3);
         check("bp.write.addr",  write_addr_o,  6'h3C);
         check("bp.write.tag",   write_tag_o,   22'h2A);
`ifdef SNITCH_ICACHE_ERR_NO_ALLOC_EN
         check("bp.write.set",   write_set_o,   2'd1);
`else
         check("bp.write.set",   write_set_o,   2'd2);
`endif
         check("bp.write.in_ready", in_ready_o, 1'b0);
         tick();
      end
      write_ready_i = 1'b1;
      tick();
      write_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp.resp.valid",    rsp_valid_o, 1'b1);
         check("bp.resp.data",     rsp_data_o,  D3);
         check("bp.resp.id",       rsp_id_o,    4'd9);
         check("bp.resp.in_ready", in_ready_o,  1'b0);
         tick();
      end
      rsp_ready_i = 1'b1;
      tick();
      #1;
      check("bp.hit_after.data",     rsp_data_o, D_HIT);
      check("bp.hit_after.id",       rsp_id_o,   4'd4);
      check("bp.hit_after.in_ready", in_ready_o, 1'b1);
      in_valid_i = 1'b0;
      in_hit_i   = 1'b0;
      tick();

      // Reset while waiting for the refill beat.
      in_valid_i      = 1'b1;
      in_hit_i        = 1'b0;
      in_addr_i       = 32'h0000_1000;
      in_id_i         = 4'd2;
      refill_ready_i  = 1'b1;
      refill_rvalid_i = 1'b0;
      write_ready_i   = 1'b1;
      rsp_ready_i     = 1'b1;
      #1;
      check("rst_wait.accept", in_ready_o, 1'b1);
      tick();
      in_valid_i = 1'b0;
      tick();
      check("rst_wait.refill_rready", refill_rready_o, 1'b1);
      refill_rvalid_i = 1'b1;
      refill_data_i   = D4;
      rst_i           = 1'b1;
      #1;
      check_quiet("rst_wait.assert");
      tick();
      tick();
      check_quiet("rst_wait.held");
      rst_i           = 1'b0;
      refill_rvalid_i = 1'b0;
      #1;
      check("rst_wait.idle", in_ready_o, 1'b1);
      tick();

      // Clean miss after reset: victim restarts at way 0.
      miss_all_ready("after_rst", 32'h0004_5670, 4'd11, D5, 1'b0,
                     32'h0004_5670, 6'h27, 22'h115, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
